// File: rtl/pkg_uart.sv
// Shared UART definitions: TX FSM state encoding and line-level constants.
// Latency: none (types and constants only).
// Backpressure: n/a.
package pkg_uart;

  // TX_PARITY is only entered when the parity build option is enabled
  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  localparam int   UART_DATA_BITS = 8;
  localparam logic UART_IDLE      = 1'b1;
  localparam logic UART_START     = 1'b0;

endpackage

// File: rtl/fifo_sync.sv
// Synchronous FIFO with occupancy count; pointers wrap modulo DEPTH (power of two).
// Latency: a pushed entry is visible on dout/empty one cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty.
module fifo_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  // full/empty are from the registered count, so a push while full is rejected
  // even when a pop happens on the same edge
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage write; no reset needed, contents are qualified by count
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/putc_uart_tx.sv
// Buffered UART TX: FIFO absorbs putc bursts, FSM serialises 8N1 (8E1 with PUTC_UART_TX_PARITY_EN).
// Latency: putc at edge E0 -> start bit on tx after E1 when idle; frame is 10 (11) bit-times.
// Backpressure: full flags a saturated FIFO; pushes while full are dropped and set sticky overflow.
module putc_uart_tx
  import pkg_uart::*;
#(
  parameter int CLK_FREQ = 12_000_000,
  parameter int BAUD     = 115200,
  parameter int DEPTH    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      putc,
  input  logic [UART_DATA_BITS-1:0] putc_char,
  output logic                      full,
  output logic                      busy,
  output logic                      overflow,
  output logic                      tx
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int BW           = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CW           = $clog2(DEPTH) + 1;

  tx_state_t                 state_q;
  logic [BW-1:0]             baud_q;
  logic [2:0]                bit_q;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic                      tx_q;
  logic                      overflow_q;
`ifdef PUTC_UART_TX_PARITY_EN
  logic                      par_q;
`endif

  logic [UART_DATA_BITS-1:0] fifo_dout;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [CW-1:0]             fifo_count;
  logic                      last_clk;
  logic                      pop_d;

  assign last_clk = (baud_q == BW'(CLKS_PER_BIT - 1));
  // Pop from idle, or on the final stop-bit cycle to chain frames without a gap
  assign pop_d    = !fifo_empty &&
                    ((state_q == TX_IDLE) || ((state_q == TX_STOP) && last_clk));

  fifo_sync #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (putc),
    .din   (putc_char),
    .pop   (pop_d),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign full     = fifo_full;
  assign busy     = (fifo_count != '0) || (state_q != TX_IDLE);
  assign overflow = overflow_q;
  assign tx       = tx_q;

  // Sticky overflow: any push attempt that the FIFO had to refuse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) overflow_q <= 1'b0;
    else if (putc && fifo_full) overflow_q <= 1'b1;
  end

  // TX FSM, baud counter, shift register and registered line output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= TX_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= UART_IDLE;
`ifdef PUTC_UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        TX_IDLE: begin
          baud_q <= '0;
          tx_q   <= UART_IDLE;
          if (pop_d) begin
            shift_q <= fifo_dout;
            bit_q   <= '0;
            state_q <= TX_START;
            tx_q    <= UART_START;
`ifdef PUTC_UART_TX_PARITY_EN
            par_q   <= ^fifo_dout;
`endif
          end
        end
        TX_START: begin
          if (last_clk) begin
            baud_q  <= '0;
            state_q <= TX_DATA;
            tx_q    <= shift_q[0];
          end else begin
            baud_q  <= baud_q + BW'(1);
          end
        end
        TX_DATA: begin
          if (last_clk) begin
            baud_q  <= '0;
            shift_q <= {1'b0, shift_q[UART_DATA_BITS-1:1]};
            if (bit_q == 3'(UART_DATA_BITS - 1)) begin
`ifdef PUTC_UART_TX_PARITY_EN
              state_q <= TX_PARITY;
              tx_q    <= par_q;
`else
              state_q <= TX_STOP;
              tx_q    <= UART_IDLE;
`endif
            end else begin
              bit_q <= bit_q + 3'd1;
              tx_q  <= shift_q[1];
            end
          end else begin
            baud_q  <= baud_q + BW'(1);
          end
        end
`ifdef PUTC_UART_TX_PARITY_EN
        TX_PARITY: begin
          if (last_clk) begin
            baud_q  <= '0;
            state_q <= TX_STOP;
            tx_q    <= UART_IDLE;
          end else begin
            baud_q  <= baud_q + BW'(1);
          end
        end
`endif
        TX_STOP: begin
          if (last_clk) begin
            baud_q <= '0;
            if (pop_d) begin
              shift_q <= fifo_dout;
              bit_q   <= '0;
              state_q <= TX_START;
              tx_q    <= UART_START;
`ifdef PUTC_UART_TX_PARITY_EN
              par_q   <= ^fifo_dout;
`endif
            end else begin
              state_q <= TX_IDLE;
              tx_q    <= UART_IDLE;
            end
          end else begin
            baud_q  <= baud_q + BW'(1);
          end
        end
        default: begin
          state_q <= TX_IDLE;
          baud_q  <= '0;
          tx_q    <= UART_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_putc_uart_tx.sv
// Testbench for putc_uart_tx: directed bursts plus random putc traffic against a frame-level model.
// Model tracks FIFO contents as a queue and each frame as a start edge plus bit-time arithmetic.
// Outputs sampled on the falling clock edge; inputs driven on the falling edge.
module tb_putc_uart_tx;

  localparam int CLK_FREQ = 12_000_000;
  localparam int BAUD     = 3_000_000;
  localparam int DEPTH    = 4;
  localparam int C        = CLK_FREQ / BAUD;
`ifdef PUTC_UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic       clk;
  logic       rst;
  logic       putc;
  logic [7:0] putc_char;
  logic       full;
  logic       busy;
  logic       overflow;
  logic       tx;

  int n_checks;
  int n_errors;

  // Reference model state
  logic [7:0] mq[$];
  logic       m_idle;
  logic       m_ovf;
  logic [7:0] m_char;
  int         m_start;
  int         m_end;
  int         cyc;

  putc_uart_tx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD),
    .DEPTH    (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .putc      (putc),
    .putc_char (putc_char),
    .full      (full),
    .busy      (busy),
    .overflow  (overflow),
    .tx        (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  // Line level for bit position idx of a frame carrying ch
  function automatic logic frame_bit(input logic [7:0] ch, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return ch[idx-1];
    if (FRAME_BITS == 11 && idx == 9) return ^ch;
    return 1'b1;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_idle  = 1'b1;
    m_ovf   = 1'b0;
    m_char  = 8'h00;
    m_start = 0;
    m_end   = 0;
  endtask

  task automatic check_outputs();
    logic exp_tx;
    if (m_idle) exp_tx = 1'b1;
    else        exp_tx = frame_bit(m_char, (cyc - m_start) / C);
    check("tx", 32'(tx), 32'(exp_tx));
    check("busy", 32'(busy), 32'((mq.size() != 0) || !m_idle));
    check("full", 32'(full), 32'(mq.size() == DEPTH));
    check("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  // One clock: drive inputs, advance the model at the rising edge, compare at the falling edge
  task automatic step(input logic p, input logic [7:0] c);
    logic pre_full;
    logic do_pop;
    putc      = p;
    putc_char = c;
    @(posedge clk);
    cyc++;
    pre_full = (mq.size() == DEPTH);
    do_pop   = (mq.size() > 0) && (m_idle || cyc == m_end);
    if (p && pre_full) m_ovf = 1'b1;
    if (do_pop) begin
      m_char  = mq.pop_front();
      m_start = cyc;
      m_end   = cyc + FRAME_BITS * C;
      m_idle  = 1'b0;
    end else if (!m_idle && cyc == m_end) begin
      m_idle = 1'b1;
    end
    if (p && !pre_full) mq.push_back(c);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    cyc       = 0;
    rst       = 1'b1;
    putc      = 1'b0;
    putc_char = 8'h00;
    model_reset();

    // Reset state
    @(negedge clk);
    check_outputs();
    rst = 1'b0;

    // Single character, then let it drain
    step(1'b1, 8'h41);
    idle(FRAME_BITS * C + 8);

    // Three back-to-back characters
    step(1'b1, 8'h55);
    step(1'b1, 8'hAA);
    step(1'b1, 8'h0F);
    idle(3 * FRAME_BITS * C + 8);

    // Six pushes while idle: fifth fills the FIFO, sixth overflows
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h10 + i));
    check("full_after_burst", 32'(full), 32'(1));
    check("overflow_after_burst", 32'(overflow), 32'(1));
    // Keep it full, then push on exactly the stop-bit pop edge
    while (cyc + 1 != m_end) step(1'b0, 8'h00);
    check("full_before_pop", 32'(full), 32'(1));
    step(1'b1, 8'hEE);
    check("full_after_pop_push", 32'(full), 32'(0));
    check("depth_after_pop_push", 32'(mq.size()), 32'(DEPTH - 1));
    idle(6 * FRAME_BITS * C);

    // Random traffic with varying push density
    for (int blk = 0; blk < 8; blk++) begin
      int dens;
      dens = $urandom_range(1, 8);
      for (int i = 0; i < 250; i++)
        step(($urandom_range(0, 15) < dens), 8'($urandom));
    end
    idle(DEPTH * FRAME_BITS * C + 50);

    // Async reset during data bit 3
    step(1'b1, 8'h30);
    step(1'b1, 8'h31);
    while ((cyc - m_start) != 4 * C + 1) step(1'b0, 8'h00);
    check("tx_bit3_low", 32'(tx), 32'(0));
    #2 rst = 1'b1;
    #1;
    check("rst_tx", 32'(tx), 32'(1));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_full", 32'(full), 32'(0));
    check("rst_overflow", 32'(overflow), 32'(0));
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    idle(3 * FRAME_BITS * C);

    // Traffic resumes normally after reset
    step(1'b1, 8'h07);
    idle(FRAME_BITS * C + 4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
